rblwe_sched: RTL and testbench
==============================

RBLWE_SCHED -- requirements
Module: rblwe_sched

Interface
REQ-001 Parameter N_BYTES, default 256: ciphertext bytes per decryption; equals message bits per decryption.
REQ-002 Parameter DRAIN_CYC, default 2: idle cycles after the last core_valid before the next load.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; shared with the decryption core.
REQ-005 req  in  2  per-requester decryption request; held high until the matching done pulse.
REQ-006 gnt  out  2  one-hot grant; high from arbitration until the done pulse.
REQ-007 done  out  2  one-cycle pulse to the granted requester; msg_out is valid in that cycle.
REQ-008 msg_out  out  256  decrypted message; bit i is the i-th core_valid bit.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 mem_rd_en  out  1  ciphertext read strobe.
REQ-011 mem_rd_sel  out  1  requester index being read.
REQ-012 mem_rd_addr  out  8  byte/bit index being read.
REQ-013 mem_c1  in  8  c1 byte; valid 1 cycle after mem_rd_en.
REQ-014 mem_c2  in  8  c2 byte; valid 1 cycle after mem_rd_en.
REQ-015 mem_r2  in  1  r2 bit; valid 1 cycle after mem_rd_en.
REQ-016 core_load  out  1  load strobe to the core.
REQ-017 core_c1  out  8  byte to the core.
REQ-018 core_c2  out  8  byte to the core.
REQ-019 core_r2  out  1  bit to the core.
REQ-020 core_start  out  1  one-cycle start to the core.
REQ-021 core_msg  in  1  message bit from the core.
REQ-022 core_valid  in  1  qualifies core_msg.

Function
REQ-023 FSM states SHALL be IDLE, ARB, FETCH, START, COLLECT, DRAIN, DONE.
REQ-024 IDLE SHALL go to ARB when any req bit is high.
REQ-025 ARB SHALL be one cycle and grant round-robin: a single request is granted directly; with both high, the requester not served last wins; after reset, requester 0 has priority.
REQ-026 FETCH SHALL assert mem_rd_en for exactly N_BYTES consecutive cycles, with mem_rd_addr running 0..255 and mem_rd_sel = granted index.
REQ-027 core_load SHALL be high for exactly N_BYTES consecutive cycles, delayed 1 cycle from mem_rd_en.
REQ-028 core_c1, core_c2 and core_r2 SHALL be the mem data returned for the same address, aligned with core_load; they SHALL be zero when core_load is low.
REQ-029 START SHALL follow the last core_load cycle and assert core_start for exactly one cycle.
REQ-030 COLLECT SHALL use an 8-bit wrapping counter starting at 0; on each core_valid, msg_out[count] <= core_msg and the counter increments.
REQ-031 COLLECT SHALL exit to DRAIN on the cycle of the 256th core_valid; core_valid outside COLLECT SHALL be ignored.
REQ-032 DRAIN SHALL last exactly DRAIN_CYC cycles, then enter DONE.
REQ-033 DONE SHALL last one cycle: it pulses done[gnt], updates the last-served pointer, clears gnt in the following cycle, then returns to IDLE.
REQ-034 A req deasserted while granted SHALL NOT abort the sequence; the done pulse is still issued.
REQ-035 msg_out SHALL hold its value from DONE until the next COLLECT begins.
REQ-036 A request arriving during a busy period SHALL wait; there is no queueing beyond the held req level.

Reset
REQ-037 On reset assertion, at any state, all outputs SHALL immediately go to 0: gnt, done, busy, mem_rd_en, mem_rd_sel, mem_rd_addr, core_load, core_c1, core_c2, core_r2, core_start and msg_out.
REQ-038 On reset assertion, state SHALL go to IDLE, all counters SHALL clear and the round-robin pointer SHALL favour requester 0; no partial result is delivered.

Verification
REQ-039 req=01, c1[k]=k, c2[k]=0, r2=0, core model returns alternating bits -> gnt=01; 256 core_load cycles with core_c1 = 0..255; one core_start; msg_out = 0x5555...55; one done[0] pulse.
REQ-040 req=11 from reset -> served order 0, 1, 0, 1 across four back-to-back decryptions; gnt is always one-hot.
REQ-041 Sequence check -> mem_rd_en rise to core_load rise is exactly 1 cycle; core_start rises exactly 1 cycle after core_load falls.
REQ-042 reset pulsed mid-FETCH at addr 100 -> all outputs are 0 in the same cycle; the next request restarts at addr 0; no done is issued.
REQ-043 core_valid gaps (valid every 3rd cycle) -> msg_out bits are still packed in order; done fires DRAIN_CYC+1 cycles after the 256th valid.
REQ-044 req[0] dropped during COLLECT -> sequence completes and the done[0] pulse is still issued.

Source files
------------

// File: rtl/rblwe_sched.sv
// ---------------------------------------------------------------------------
// rblwe_sched
//
// Shares one RBLWE decryption core between two requesters. A requester
// raises its req bit and holds it. The scheduler then does the following:
//   1. arbitrates round-robin and grants the winner;
//   2. streams that requester's N_BYTES ciphertext bytes (c1, c2) and r2
//      bits from memory into the core;
//   3. starts the core and collects N_BYTES message bits from the core;
//   4. lets the core drain and pulses done to the winner, with the
//      assembled message on msg_out.
//
// Ports
//   clk, reset        single rising-edge clock; asynchronous active-high reset
//   req[1:0]          per-requester request level
//   gnt[1:0]          one-hot grant, high from arbitration to the done pulse
//   done[1:0]         one-cycle completion pulse to the granted requester
//   msg_out           collected message, bit i = i-th valid core bit
//   busy              high whenever the scheduler is not idle
//   mem_rd_en/sel/addr  ciphertext read port (data returns one cycle later)
//   mem_c1/c2/r2      ciphertext read data
//   core_load, core_c1/c2/r2  load stream into the core
//   core_start        one-cycle start pulse to the core
//   core_msg/valid    message bit stream back from the core
// ---------------------------------------------------------------------------
module rblwe_sched #(
    parameter int N_BYTES   = 256,
    parameter int DRAIN_CYC = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req,
    output logic [1:0]         gnt,
    output logic [1:0]         done,
    output logic [N_BYTES-1:0] msg_out,
    output logic               busy,
    output logic               mem_rd_en,
    output logic               mem_rd_sel,
    output logic [7:0]         mem_rd_addr,
    input  logic [7:0]         mem_c1,
    input  logic [7:0]         mem_c2,
    input  logic               mem_r2,
    output logic               core_load,
    output logic [7:0]         core_c1,
    output logic [7:0]         core_c2,
    output logic               core_r2,
    output logic               core_start,
    input  logic               core_msg,
    input  logic               core_valid
);

    localparam int CNT_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    // One extra bit so FETCH can span N_BYTES read cycles plus the final
    // load cycle that consumes the last returned byte.
    localparam int FET_W = CNT_W + 1;
    localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        FETCH,
        START,
        COLLECT,
        DRAIN,
        DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [1:0]         gnt_q;
    logic               sel_q;
    logic               last_q;
    logic [FET_W-1:0]   fetch_cnt_q;
    logic [CNT_W-1:0]   col_cnt_q;
    logic [DRN_W-1:0]   drn_cnt_q;
    logic               vld_p0;
    logic               vld_p1;
    logic               fetch_last;
    logic               collect_hit;
    logic               collect_last;
    logic               drain_last;
    logic               winner;

    // Round-robin choice: with both requesting, the one not served last
    // wins; otherwise the lone requester is taken.
    function automatic logic arb_pick(input logic [1:0] r, input logic last);
        if (r == 2'b11) begin
            return ~last;
        end
        return r[1];
    endfunction

    assign winner       = arb_pick(req, last_q);
    assign fetch_last   = (state_q == FETCH) && (fetch_cnt_q == FET_W'(N_BYTES));
    assign collect_hit  = (state_q == COLLECT) && core_valid;
    assign collect_last = collect_hit && (col_cnt_q == CNT_W'(N_BYTES - 1));
    assign drain_last   = (drn_cnt_q == DRN_W'(DRAIN_CYC - 1));

    // Stage p0: memory read request
    assign vld_p0      = (state_q == FETCH) && (fetch_cnt_q < FET_W'(N_BYTES));
    assign mem_rd_en   = vld_p0;
    assign mem_rd_sel  = vld_p0 ? sel_q : 1'b0;
    assign mem_rd_addr = vld_p0 ? 8'(fetch_cnt_q[CNT_W-1:0]) : 8'd0;

    // Stage p1: returned memory data forwarded to the core
    assign core_load = vld_p1;
    assign core_c1   = vld_p1 ? mem_c1 : 8'd0;
    assign core_c2   = vld_p1 ? mem_c2 : 8'd0;
    assign core_r2   = vld_p1 ? mem_r2 : 1'b0;

    assign core_start = (state_q == START);
    assign busy       = (state_q != IDLE);
    assign gnt        = gnt_q;
    assign done       = (state_q == DONE) ? gnt_q : 2'b00;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                // A request withdrawn before arbitration is simply dropped.
                if (|req) begin
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if (fetch_last) begin
                    state_d = START;
                end
            end
            START: begin
                state_d = COLLECT;
            end
            COLLECT: begin
                if (collect_last) begin
                    if (DRAIN_CYC == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant and round-robin bookkeeping. last_q resets to 1 so requester 0
    // wins the first contested arbitration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q  <= 2'b00;
            sel_q  <= 1'b0;
            last_q <= 1'b1;
        end else begin
            if ((state_q == ARB) && (|req)) begin
                sel_q <= winner;
                gnt_q <= winner ? 2'b10 : 2'b01;
            end
            if (state_q == DONE) begin
                last_q <= sel_q;
                gnt_q  <= 2'b00;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            col_cnt_q   <= '0;
            drn_cnt_q   <= '0;
            vld_p1      <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;

            if (state_q == FETCH) begin
                fetch_cnt_q <= fetch_cnt_q + 1'b1;
            end else begin
                fetch_cnt_q <= '0;
            end

            // Counter wraps back to 0 on the final bit, so it is already
            // clear for the next decryption; START clears it defensively.
            if (state_q == START) begin
                col_cnt_q <= '0;
            end else if (collect_hit) begin
                col_cnt_q <= col_cnt_q + 1'b1;
            end

            if (state_q == DRAIN) begin
                drn_cnt_q <= drn_cnt_q + 1'b1;
            end else begin
                drn_cnt_q <= '0;
            end
        end
    end

    // Message bits are written in place and held until the next COLLECT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msg_out <= '0;
        end else if (collect_hit) begin
            msg_out[col_cnt_q] <= core_msg;
        end
    end

endmodule

// File: tb/tb_rblwe_sched.sv
module tb_rblwe_sched;

    localparam int NB     = 256;
    localparam int DC     = 2;
    localparam int BUDGET = 3000;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic [1:0]    gnt;
    logic [1:0]    done;
    logic [NB-1:0] msg_out;
    logic          busy;
    logic          mem_rd_en;
    logic          mem_rd_sel;
    logic [7:0]    mem_rd_addr;
    logic [7:0]    mem_c1;
    logic [7:0]    mem_c2;
    logic          mem_r2;
    logic          core_load;
    logic [7:0]    core_c1;
    logic [7:0]    core_c2;
    logic          core_r2;
    logic          core_start;
    logic          core_msg;
    logic          core_valid;

    int n_checks = 0;
    int n_fail   = 0;

    rblwe_sched #(.N_BYTES(NB), .DRAIN_CYC(DC)) dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt), .done(done),
        .msg_out(msg_out), .busy(busy), .mem_rd_en(mem_rd_en),
        .mem_rd_sel(mem_rd_sel), .mem_rd_addr(mem_rd_addr),
        .mem_c1(mem_c1), .mem_c2(mem_c2), .mem_r2(mem_r2),
        .core_load(core_load), .core_c1(core_c1), .core_c2(core_c2),
        .core_r2(core_r2), .core_start(core_start), .core_msg(core_msg),
        .core_valid(core_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Ciphertext memory: registered read, data one cycle after the strobe,
    // garbage when not read so unqualified data must be masked.
    logic [7:0] c1_mem [2][NB];
    logic [7:0] c2_mem [2][NB];
    logic       r2_mem [2][NB];

    always @(posedge clk) begin
        if (mem_rd_en === 1'b1) begin
            mem_c1 <= c1_mem[mem_rd_sel][mem_rd_addr];
            mem_c2 <= c2_mem[mem_rd_sel][mem_rd_addr];
            mem_r2 <= r2_mem[mem_rd_sel][mem_rd_addr];
        end else begin
            mem_c1 <= 8'($urandom);
            mem_c2 <= 8'($urandom);
            mem_r2 <= 1'($urandom);
        end
    end

    // Core model: after core_start, return NB bits of the queued pattern,
    // with 'gap' idle cycles before each valid. Outside a run it may toggle
    // core_valid randomly, which the scheduler must ignore.
    int            gap = 0;
    bit            stray_en = 1'b0;
    int            last_valid_cyc = 0;
    logic [NB-1:0] pat_q [$];
    logic [NB-1:0] cur_pat;

    initial begin
        core_valid = 1'b0;
        core_msg   = 1'b0;
        forever begin
            @(negedge clk);
            if (core_start === 1'b1) begin
                cur_pat    = (pat_q.size() > 0) ? pat_q.pop_front() : '0;
                core_valid = stray_en ? 1'($urandom) : 1'b0;
                core_msg   = 1'($urandom);
                @(negedge clk);
                for (int i = 0; i < NB; i++) begin
                    for (int g = 0; g < gap; g++) begin
                        core_valid = 1'b0;
                        core_msg   = 1'($urandom);
                        @(negedge clk);
                    end
                    core_valid     = 1'b1;
                    core_msg       = cur_pat[i];
                    last_valid_cyc = cyc;
                    @(negedge clk);
                end
                core_valid = 1'b0;
            end else begin
                core_valid = stray_en ? 1'($urandom) : 1'b0;
                core_msg   = 1'($urandom);
            end
        end
    end

    // Observation: record run lengths, latencies and per-beat errors.
    int            exp_q [$];
    int            cur_sel = 0;
    logic          prev_rd = 1'b0;
    logic          prev_load = 1'b0;
    int            rd_run = 0, ld_run = 0, rd_rise_cyc = 0, last_load_cyc = 0;
    int            onehot_err = 0, addr_err = 0, data_err = 0, zero_err = 0;
    int            start_cnt = 0, done_cnt = 0;
    int            rd_runs_q [$], ld_runs_q [$], lat_q [$], slat_q [$], dlat_q [$];
    logic [1:0]    gnt_rise_q [$], done_q [$];
    logic [NB-1:0] msg_q [$];

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (gnt !== 2'b00 && !$onehot(gnt)) onehot_err++;
            if (mem_rd_en === 1'b1 && !prev_rd) begin
                rd_rise_cyc = cyc;
                rd_run      = 0;
                cur_sel     = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
                gnt_rise_q.push_back(gnt);
            end
            if (mem_rd_en === 1'b1) begin
                if (mem_rd_addr !== 8'(rd_run) || mem_rd_sel !== 1'(cur_sel)) addr_err++;
                rd_run++;
            end
            if (mem_rd_en !== 1'b1 && prev_rd) rd_runs_q.push_back(rd_run);
            if (core_load === 1'b1 && !prev_load) begin
                lat_q.push_back(cyc - rd_rise_cyc);
                ld_run = 0;
            end
            if (core_load === 1'b1) begin
                if (ld_run >= NB ||
                    core_c1 !== c1_mem[cur_sel][ld_run] ||
                    core_c2 !== c2_mem[cur_sel][ld_run] ||
                    core_r2 !== r2_mem[cur_sel][ld_run]) data_err++;
                ld_run++;
                last_load_cyc = cyc;
            end else if (core_c1 !== 8'd0 || core_c2 !== 8'd0 || core_r2 !== 1'b0) begin
                zero_err++;
            end
            if (core_load !== 1'b1 && prev_load) ld_runs_q.push_back(ld_run);
            if (core_start === 1'b1) begin
                start_cnt++;
                slat_q.push_back(cyc - last_load_cyc);
            end
            if (done !== 2'b00) begin
                done_cnt++;
                done_q.push_back(done);
                msg_q.push_back(msg_out);
                dlat_q.push_back(cyc - last_valid_cyc);
            end
            prev_rd   = (mem_rd_en === 1'b1);
            prev_load = (core_load === 1'b1);
        end
    end

    task automatic clear_mon();
        exp_q.delete(); pat_q.delete();
        rd_runs_q.delete(); ld_runs_q.delete(); lat_q.delete(); slat_q.delete();
        dlat_q.delete(); gnt_rise_q.delete(); done_q.delete(); msg_q.delete();
        prev_rd = 1'b0; prev_load = 1'b0;
        onehot_err = 0; addr_err = 0; data_err = 0; zero_err = 0;
        start_cnt = 0; done_cnt = 0;
    endtask

    // Reference arbitration: the lone requester, or with both requesting
    // the one that was not served last.
    int last_served = 1;

    function automatic int rr_model(input logic [1:0] r, input int last);
        if (r == 2'b11) return (last == 0) ? 1 : 0;
        return (r == 2'b10) ? 1 : 0;
    endfunction

    function automatic logic [1:0] onehot_of(input int s);
        return (s == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [NB-1:0] rand_pat();
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) p[i] = 1'($urandom);
        return p;
    endfunction

    task automatic fill_random();
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < NB; k++) begin
                c1_mem[s][k] = 8'($urandom);
                c2_mem[s][k] = 8'($urandom);
                r2_mem[s][k] = 1'($urandom);
            end
    endtask

    task automatic wait_done(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done_cnt >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [NB+33:0] all_outs();
        return {gnt, done, busy, mem_rd_en, mem_rd_sel, mem_rd_addr, core_load,
                core_c1, core_c2, core_r2, core_start, msg_out};
    endfunction

    task automatic test_reset();
        @(negedge clk); #1;
        n_checks++;
        if (all_outs() !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %0h required 0", all_outs());
        end
        reset = 1'b0;
        last_served = 1;
        repeat (5) @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || gnt !== 2'b00) begin
            n_fail++; $display("FAIL idle_after_reset: busy=%0b gnt=%0b required 0/00", busy, gnt);
        end
    endtask

    task automatic test_basic();
        bit            ok;
        int            p;
        logic [NB-1:0] exp_msg;
        clear_mon();
        fill_random();
        for (int k = 0; k < NB; k++) begin
            c1_mem[0][k] = 8'(k);
            c2_mem[0][k] = 8'd0;
            r2_mem[0][k] = 1'b0;
        end
        for (int i = 0; i < NB; i++) exp_msg[i] = (i % 2 == 0);
        p = rr_model(2'b01, last_served);
        last_served = p;
        exp_q.push_back(p);
        pat_q.push_back(exp_msg);
        gap = 0; stray_en = 1'b1;
        req = 2'b01;
        wait_done(1, BUDGET, ok);
        req = 2'b00;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_timeout: done not seen in %0d cycles", BUDGET); end
        n_checks++;
        if (gnt_rise_q.size() < 1 || gnt_rise_q[0] !== 2'b01) begin
            n_fail++; $display("FAIL basic_gnt: got %0b required 01", (gnt_rise_q.size() > 0) ? gnt_rise_q[0] : 2'bxx);
        end
        n_checks++;
        if (rd_runs_q.size() != 1 || rd_runs_q[0] != NB) begin
            n_fail++; $display("FAIL basic_rd_len: runs=%0d first=%0d required 1 run of %0d", rd_runs_q.size(), (rd_runs_q.size() > 0) ? rd_runs_q[0] : -1, NB);
        end
        n_checks++;
        if (ld_runs_q.size() != 1 || ld_runs_q[0] != NB) begin
            n_fail++; $display("FAIL basic_load_len: runs=%0d first=%0d required 1 run of %0d", ld_runs_q.size(), (ld_runs_q.size() > 0) ? ld_runs_q[0] : -1, NB);
        end
        n_checks++;
        if (lat_q.size() != 1 || lat_q[0] != 1) begin
            n_fail++; $display("FAIL rd_to_load_latency: got %0d required 1", (lat_q.size() > 0) ? lat_q[0] : -1);
        end
        n_checks++;
        if (start_cnt != 1 || slat_q.size() != 1 || slat_q[0] != 1) begin
            n_fail++; $display("FAIL load_to_start: starts=%0d gap=%0d required 1 start 1 cycle after last load", start_cnt, (slat_q.size() > 0) ? slat_q[0] : -1);
        end
        n_checks++;
        if (addr_err != 0 || data_err != 0 || zero_err != 0) begin
            n_fail++; $display("FAIL basic_stream: addr_err=%0d data_err=%0d zero_err=%0d required 0", addr_err, data_err, zero_err);
        end
        n_checks++;
        if (done_q.size() != 1 || done_q[0] !== 2'b01 || msg_q[0] !== exp_msg) begin
            n_fail++; $display("FAIL basic_result: done=%0b msg=%0h required 01 / %0h", (done_q.size() > 0) ? done_q[0] : 2'bxx, (msg_q.size() > 0) ? msg_q[0] : '0, exp_msg);
        end
        n_checks++;
        if (dlat_q.size() != 1 || dlat_q[0] != DC + 1) begin
            n_fail++; $display("FAIL basic_done_latency: got %0d required %0d", (dlat_q.size() > 0) ? dlat_q[0] : -1, DC + 1);
        end
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (gnt !== 2'b00 || busy !== 1'b0 || done_cnt != 1) begin
            n_fail++; $display("FAIL basic_release: gnt=%0b busy=%0b dones=%0d required 00/0/1", gnt, busy, done_cnt);
        end
        n_checks++;
        if (msg_out !== exp_msg) begin
            n_fail++; $display("FAIL msg_hold: got %0h required %0h", msg_out, exp_msg);
        end
    endtask

    task automatic test_reset_mid_fetch();
        bit            found, ok;
        int            p;
        logic [NB-1:0] pat;
        clear_mon();
        fill_random();
        gap = 0; stray_en = 1'b0;
        p = rr_model(2'b11, last_served);
        exp_q.push_back(p);
        req = 2'b11;
        found = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk); #1;
            if (mem_rd_en === 1'b1 && mem_rd_addr === 8'd100) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL midfetch_reach: address 100 not reached"); end
        n_checks++;
        if (mem_rd_sel !== 1'(p)) begin
            n_fail++; $display("FAIL midfetch_rr_sel: got %0b required %0d", mem_rd_sel, p);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (all_outs() !== '0) begin
            n_fail++; $display("FAIL midfetch_reset_outputs: got %0h required 0", all_outs());
        end
        req = 2'b00;
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_cnt != 0) begin
            n_fail++; $display("FAIL midfetch_no_done: got %0d dones required 0", done_cnt);
        end
        clear_mon();
        reset = 1'b0;
        last_served = 1;
        @(negedge clk);
        p = rr_model(2'b11, last_served);
        last_served = p;
        exp_q.push_back(p);
        pat = rand_pat();
        pat_q.push_back(pat);
        req = 2'b11;
        wait_done(1, BUDGET, ok);
        req = 2'b00;
        n_checks++;
        if (!ok || rd_runs_q.size() != 1 || rd_runs_q[0] != NB || addr_err != 0) begin
            n_fail++; $display("FAIL restart_fetch: ok=%0b runs=%0d addr_err=%0d required full fetch from 0", ok, rd_runs_q.size(), addr_err);
        end
        n_checks++;
        if (done_q.size() != 1 || done_q[0] !== onehot_of(p) || msg_q[0] !== pat) begin
            n_fail++; $display("FAIL restart_result: done=%0b required %0b", (done_q.size() > 0) ? done_q[0] : 2'bxx, onehot_of(p));
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit            ok;
        int            exp_s [4];
        logic [NB-1:0] pats [4];
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        clear_mon();
        reset = 1'b0;
        last_served = 1;
        fill_random();
        gap = 0; stray_en = 1'b1;
        for (int j = 0; j < 4; j++) begin
            exp_s[j] = rr_model(2'b11, last_served);
            last_served = exp_s[j];
            exp_q.push_back(exp_s[j]);
            pats[j] = rand_pat();
            pat_q.push_back(pats[j]);
        end
        @(negedge clk);
        req = 2'b11;
        wait_done(4, 4 * BUDGET, ok);
        req = 2'b00;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_timeout: %0d of 4 dones", done_cnt); end
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (done_q.size() <= j || done_q[j] !== onehot_of(exp_s[j]) ||
                gnt_rise_q[j] !== onehot_of(exp_s[j]) || msg_q[j] !== pats[j] ||
                rd_runs_q[j] != NB) begin
                n_fail++; $display("FAIL b2b_txn%0d: done=%0b required %0b", j, (done_q.size() > j) ? done_q[j] : 2'bxx, onehot_of(exp_s[j]));
            end
        end
        n_checks++;
        if (onehot_err != 0 || addr_err != 0 || data_err != 0 || zero_err != 0 || start_cnt != 4) begin
            n_fail++; $display("FAIL b2b_stream: onehot=%0d addr=%0d data=%0d zero=%0d starts=%0d required 0/0/0/0/4", onehot_err, addr_err, data_err, zero_err, start_cnt);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_valid_gaps();
        bit            ok;
        int            p;
        logic [NB-1:0] pat;
        clear_mon();
        fill_random();
        gap = 2; stray_en = 1'b1;
        p = rr_model(2'b01, last_served);
        last_served = p;
        exp_q.push_back(p);
        pat = rand_pat();
        pat_q.push_back(pat);
        req = 2'b01;
        wait_done(1, BUDGET, ok);
        req = 2'b00;
        n_checks++;
        if (!ok || done_q.size() != 1 || msg_q[0] !== pat) begin
            n_fail++; $display("FAIL gaps_msg: ok=%0b got %0h required %0h", ok, (msg_q.size() > 0) ? msg_q[0] : '0, pat);
        end
        n_checks++;
        if (dlat_q.size() != 1 || dlat_q[0] != DC + 1) begin
            n_fail++; $display("FAIL gaps_done_latency: got %0d required %0d", (dlat_q.size() > 0) ? dlat_q[0] : -1, DC + 1);
        end
        gap = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_req_drop();
        bit            ok, started;
        int            p;
        logic [NB-1:0] pat;
        clear_mon();
        fill_random();
        gap = 0; stray_en = 1'b0;
        p = rr_model(2'b10, last_served);
        last_served = p;
        exp_q.push_back(p);
        pat = rand_pat();
        pat_q.push_back(pat);
        req = 2'b10;
        started = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk); #1;
            if (start_cnt > 0) begin
                started = 1'b1;
                break;
            end
        end
        repeat (5) @(negedge clk);
        req = 2'b00;
        #1;
        n_checks++;
        if (!started || busy !== 1'b1) begin
            n_fail++; $display("FAIL drop_still_busy: started=%0b busy=%0b required 1/1", started, busy);
        end
        wait_done(1, BUDGET, ok);
        n_checks++;
        if (!ok || done_q.size() != 1 || done_q[0] !== onehot_of(p) || msg_q[0] !== pat) begin
            n_fail++; $display("FAIL drop_done: ok=%0b done=%0b required %0b", ok, (done_q.size() > 0) ? done_q[0] : 2'bxx, onehot_of(p));
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        req   = 2'b00;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_reset_mid_fetch();
        test_back_to_back();
        test_valid_gaps();
        test_req_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
